mem_model: RTL and testbench

Synthesizable, parametrised multi-channel memory responder that services the GPU's program and data memory ports, replacing the bench-side behavioural memory class. Each channel runs an independent valid/ready handshake with a configurable fixed access latency, sharing one word array. The block is instantiated in test tops next to `gpu`, one instance per memory space, and is usable in emulation because it carries no class-based code.

---
 rtl/mem_model_pkg.sv | 18 +
 rtl/mem_model_if.sv | 39 +++
 rtl/mem_model_channel.sv | 97 +++++++++
 rtl/mem_model.sv | 97 +++++++++
 tb/tb_mem_model.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_model_pkg.sv
// Shared types and constants for the multi-channel memory responder.
package mem_model_pkg;

    localparam int LAT_CNT_BITS = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_R,
        BUSY_W,
        RESP
    } chan_state_t;

    // Counter preload for a given access latency (latency 1..15).
    function automatic logic [LAT_CNT_BITS-1:0] lat_preload(input int latency);
        return LAT_CNT_BITS'(latency - 1);
    endfunction

endpackage

// File: rtl/mem_model_if.sv
// Request/response bundle for all channels of one mem_model instance.
interface mem_model_if #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8,
    parameter int CHANNELS  = 4
);

    logic [CHANNELS-1:0]                read_valid;
    logic [CHANNELS-1:0][ADDR_BITS-1:0] read_address;
    logic [CHANNELS-1:0]                read_ready;
    logic [CHANNELS-1:0][DATA_BITS-1:0] read_data;
    logic [CHANNELS-1:0]                write_valid;
    logic [CHANNELS-1:0][ADDR_BITS-1:0] write_address;
    logic [CHANNELS-1:0][DATA_BITS-1:0] write_data;
    logic [CHANNELS-1:0]                write_ready;

    modport master (
        output read_valid,
        output read_address,
        input  read_ready,
        input  read_data,
        output write_valid,
        output write_address,
        output write_data,
        input  write_ready
    );

    modport slave (
        input  read_valid,
        input  read_address,
        output read_ready,
        output read_data,
        input  write_valid,
        input  write_address,
        input  write_data,
        output write_ready
    );

endinterface

// File: rtl/mem_model_channel.sv
// One request channel: IDLE/BUSY/RESP sequencing, latency counter and
// latched request; the array access itself is done by the parent.
module mem_model_channel
    import mem_model_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 read_valid,
    input  logic [ADDR_BITS-1:0] read_address,
    input  logic                 write_valid,
    input  logic [ADDR_BITS-1:0] write_address,
    input  logic [DATA_BITS-1:0] write_data,
    output logic                 read_ready,
    output logic                 write_ready,
    output logic                 read_fire,
    output logic                 write_fire,
    output logic [ADDR_BITS-1:0] req_addr,
    output logic [DATA_BITS-1:0] req_data
);

    localparam logic [LAT_CNT_BITS-1:0] CNT_LOAD = lat_preload(LATENCY);

    chan_state_t             state_q, state_d;
    logic [LAT_CNT_BITS-1:0] cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]    addr_q, addr_d;
    logic [DATA_BITS-1:0]    data_q, data_d;
    logic                    is_wr_q, is_wr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            is_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            is_wr_q <= is_wr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        is_wr_d     = is_wr_q;
        read_ready  = 1'b0;
        write_ready = 1'b0;
        read_fire   = 1'b0;
        write_fire  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A simultaneous write stays pending until the read has responded.
                if (read_valid) begin
                    addr_d  = read_address;
                    cnt_d   = CNT_LOAD;
                    is_wr_d = 1'b0;
                    state_d = BUSY_R;
                end else if (write_valid) begin
                    addr_d  = write_address;
                    data_d  = write_data;
                    cnt_d   = CNT_LOAD;
                    is_wr_d = 1'b1;
                    state_d = BUSY_W;
                end
            end
            BUSY_R, BUSY_W: begin
                if (cnt_q == '0) begin
                    read_fire  = (state_q == BUSY_R);
                    write_fire = (state_q == BUSY_W);
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q - LAT_CNT_BITS'(1);
                end
            end
            RESP: begin
                read_ready  = !is_wr_q;
                write_ready = is_wr_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_addr = addr_q;
    assign req_data = data_q;

endmodule

// File: rtl/mem_model.sv
// Multi-channel fixed-latency memory responder sharing one word array.
// Optional backdoor load port enabled by defining MEM_MODEL_LOAD_EN.
module mem_model
    import mem_model_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8,
    parameter int CHANNELS  = 4,
    parameter int DEPTH     = 256,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_model_if.slave           bus
`ifdef MEM_MODEL_LOAD_EN
    ,
    input  logic                 load_en,
    input  logic [ADDR_BITS-1:0] load_addr,
    input  logic [DATA_BITS-1:0] load_data
`endif
);

    localparam int IDX_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CMP_BITS = ADDR_BITS + 1;

    logic [DATA_BITS-1:0] mem [DEPTH];

    logic [CHANNELS-1:0]                rd_ready;
    logic [CHANNELS-1:0]                wr_ready;
    logic [CHANNELS-1:0]                rd_fire;
    logic [CHANNELS-1:0]                wr_fire;
    logic [CHANNELS-1:0][ADDR_BITS-1:0] ch_addr;
    logic [CHANNELS-1:0][DATA_BITS-1:0] ch_data;
    logic [CHANNELS-1:0][DATA_BITS-1:0] rd_data_q;

    function automatic logic in_range(input logic [ADDR_BITS-1:0] a);
        return {1'b0, a} < CMP_BITS'(DEPTH);
    endfunction

    function automatic logic [IDX_BITS-1:0] idx(input logic [ADDR_BITS-1:0] a);
        return a[IDX_BITS-1:0];
    endfunction

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        mem_model_channel #(
            .ADDR_BITS (ADDR_BITS),
            .DATA_BITS (DATA_BITS),
            .LATENCY   (LATENCY)
        ) u_chan (
            .clk           (clk),
            .reset         (reset),
            .read_valid    (bus.read_valid[c]),
            .read_address  (bus.read_address[c]),
            .write_valid   (bus.write_valid[c]),
            .write_address (bus.write_address[c]),
            .write_data    (bus.write_data[c]),
            .read_ready    (rd_ready[c]),
            .write_ready   (wr_ready[c]),
            .read_fire     (rd_fire[c]),
            .write_fire    (wr_fire[c]),
            .req_addr      (ch_addr[c]),
            .req_data      (ch_data[c])
        );
    end

    // Ascending loop: the highest channel's commit lands last; the load port overrides all.
    always_ff @(posedge clk) begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (!reset && wr_fire[c] && in_range(ch_addr[c])) begin
                mem[idx(ch_addr[c])] <= ch_data[c];
            end
        end
`ifdef MEM_MODEL_LOAD_EN
        if (load_en && in_range(load_addr)) begin
            mem[idx(load_addr)] <= load_data;
        end
`endif
    end

    // Reads see the array before this edge's commits.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (rd_fire[c]) begin
                    rd_data_q[c] <= in_range(ch_addr[c]) ? mem[idx(ch_addr[c])] : '0;
                end
            end
        end
    end

    assign bus.read_ready  = rd_ready;
    assign bus.write_ready = wr_ready;
    assign bus.read_data   = rd_data_q;

endmodule

// File: tb/tb_mem_model.sv
// Directed bench for mem_model with a per-channel expected-response scoreboard.
module tb_mem_model;

    localparam int AB    = 8;
    localparam int DB    = 8;
    localparam int CH    = 4;
    localparam int DEPTH = 200;
    localparam int LAT   = 2;

    typedef struct {
        bit       is_wr;
        logic [7:0] data;
        int       due;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic [7:0] model [256];
    exp_t       q [CH][$];
    int         reps [CH];

`ifdef MEM_MODEL_LOAD_EN
    logic          load_en = 1'b0;
    logic [AB-1:0] load_addr = '0;
    logic [DB-1:0] load_data = '0;
`endif

    mem_model_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .CHANNELS(CH)) bus ();

    mem_model #(
        .ADDR_BITS (AB),
        .DATA_BITS (DB),
        .CHANNELS  (CH),
        .DEPTH     (DEPTH),
        .LATENCY   (LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef MEM_MODEL_LOAD_EN
        ,
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] model_rd(input logic [7:0] a);
        return (int'(a) < DEPTH) ? model[a] : 8'h00;
    endfunction

    function automatic bit busy();
        for (int c = 0; c < CH; c++) if (q[c].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Advance to the next falling edge and score any completion pulses.
    task automatic step();
        exp_t e;
        @(negedge clk);
        for (int c = 0; c < CH; c++) begin
            if (bus.read_ready[c] || bus.write_ready[c]) begin
                check($sformatf("ch%0d_pulse_expected", c), 32'(q[c].size() != 0), 32'd1);
                if (q[c].size() != 0) begin
                    e = q[c].pop_front();
                    check($sformatf("ch%0d_ready_kind", c),
                          {30'd0, bus.read_ready[c], bus.write_ready[c]},
                          e.is_wr ? 32'd1 : 32'd2);
                    if (!e.is_wr)
                        check($sformatf("ch%0d_read_data", c), 32'(bus.read_data[c]), 32'(e.data));
                    check($sformatf("ch%0d_ready_cycle", c), cyc, e.due);
                    if (reps[c] > 0) begin
                        reps[c]--;
                        e.due = cyc + LAT + 2;
                        q[c].push_back(e);
                    end else if (e.is_wr) begin
                        bus.write_valid[c] = 1'b0;
                    end else begin
                        bus.read_valid[c] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic start_read(input int c, input logic [7:0] a, input int extra);
        exp_t e;
        e.is_wr = 1'b0;
        e.data  = model_rd(a);
        e.due   = cyc + 1 + LAT + extra;
        q[c].push_back(e);
        bus.read_address[c] = a;
        bus.read_valid[c]   = 1'b1;
    endtask

    task automatic start_write(input int c, input logic [7:0] a, input logic [7:0] d, input int extra);
        exp_t e;
        e.is_wr = 1'b1;
        e.data  = d;
        e.due   = cyc + 1 + LAT + extra;
        q[c].push_back(e);
        if (int'(a) < DEPTH) model[a] = d;
        bus.write_address[c] = a;
        bus.write_data[c]    = d;
        bus.write_valid[c]   = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy() && n < budget) begin
            step();
            n++;
        end
        check("idle_within_budget", 32'(busy()), 32'd0);
        if (busy()) begin
            for (int c = 0; c < CH; c++) begin
                q[c].delete();
                reps[c] = 0;
            end
            bus.read_valid  = '0;
            bus.write_valid = '0;
        end
        step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) model[i] = 8'h00;
        for (int c = 0; c < CH; c++) reps[c] = 0;
        bus.read_valid    = '0;
        bus.read_address  = '0;
        bus.write_valid   = '0;
        bus.write_address = '0;
        bus.write_data    = '0;

        // Reset state
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        check("reset_read_ready", 32'(bus.read_ready), 32'd0);
        check("reset_write_ready", 32'(bus.write_ready), 32'd0);
        check("reset_read_data", 32'(bus.read_data), 32'd0);

        // Single read with LATENCY=2 after loading array[5]
        start_write(0, 8'd5, 8'h3C, 0);
        wait_idle(20);
        start_read(0, 8'd5, 0);
        wait_idle(20);
        check("read_data_held", 32'(bus.read_data[0]), 32'h3C);

        // Same-edge writes to one address: highest channel wins
        start_write(1, 8'd9, 8'h11, 0);
        start_write(3, 8'd9, 8'h22, 0);
        wait_idle(20);
        start_read(3, 8'd9, 0);
        wait_idle(20);

        // Read and write together on one channel: read first, write after RESP
        start_write(2, 8'd4, 8'h01, 0);
        wait_idle(20);
        start_read(2, 8'd4, 0);
        start_write(2, 8'd4, 8'h7E, LAT + 2);
        wait_idle(30);
        start_read(2, 8'd4, 0);
        wait_idle(20);

        // Out-of-range and last in-range address with DEPTH=200
        start_read(0, 8'd250, 0);
        wait_idle(20);
        start_write(0, 8'd250, 8'h55, 0);
        wait_idle(20);
        start_read(0, 8'd250, 0);
        wait_idle(20);
        start_write(1, 8'd199, 8'h99, 0);
        wait_idle(20);
        start_read(1, 8'd199, 0);
        wait_idle(20);

        // Reset while ch0 is in BUSY_W: write abandoned, outputs cleared
        start_write(0, 8'd20, 8'h33, 0);
        wait_idle(20);
        start_write(0, 8'd20, 8'hAA, 0);
        model[20] = 8'h33;
        step();
        reset = 1'b1;
        bus.write_valid[0] = 1'b0;
        q[0].delete();
        step();
        check("midreset_read_ready", 32'(bus.read_ready), 32'd0);
        check("midreset_write_ready", 32'(bus.write_ready), 32'd0);
        check("midreset_read_data", 32'(bus.read_data), 32'd0);
        reset = 1'b0;
        step();
        check("postreset_write_ready", 32'(bus.write_ready), 32'd0);
        check("postreset_read_data", 32'(bus.read_data), 32'd0);
        repeat (6) step();
        start_read(0, 8'd20, 0);
        wait_idle(20);

        // All channels held valid for 20 cycles: one transaction per LAT+2 each
        for (int c = 0; c < CH; c++) reps[c] = 4;
        start_read(0, 8'd5, 0);
        start_read(1, 8'd9, 0);
        start_write(2, 8'd40, 8'hA5, 0);
        start_write(3, 8'd41, 8'h5A, 0);
        wait_idle(40);
        start_read(2, 8'd40, 0);
        start_read(3, 8'd41, 0);
        wait_idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
